ctrl_pipe_nway: RTL and testbench

- Parametrised successor to the fixed-width control pipeline for the N-issue RV64 core.
- Decodes ISSUE_NUM lanes of opcode/func3 in D into per-lane control bundles.
- Carries those bundles through E, M and W with per-lane valid bits, an E-stage stall, an E flush, and a branch-redirect kill of younger lanes in the same bundle.
- Also reports an in-flight instruction count and a per-lane illegal-opcode flag.

---
 rtl/ctrl_pipe_nway_if.sv | 35 +++
 rtl/ctrl_pipe_nway.sv | 108 ++++++++++
 tb/tb_ctrl_pipe_nway.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_nway_if.sv
// ctrl_pipe_nway_if: D-stage inputs, E-stage controls and E/M/W control outputs of the N-issue control pipeline
//   master: drives validD/opcodeD/func3D, stallE/flushE/redirect_vE/redirect_laneE; observes stage bundles
//   slave : the pipeline itself
interface ctrl_pipe_nway_if #(
    parameter int ISSUE_NUM = 4,
    parameter int CNT_W     = 5
);
    logic [ISSUE_NUM-1:0]   validD;
    logic [7*ISSUE_NUM-1:0] opcodeD;
    logic [3*ISSUE_NUM-1:0] func3D;
    logic                   stallE;
    logic                   flushE;
    logic                   redirect_vE;
    logic [2:0]             redirect_laneE;
    logic [ISSUE_NUM-1:0]   validE, regwriteE, memreadE, memwriteE, jalE, jalrE, branchE;
    logic [3*ISSUE_NUM-1:0] func3E;
    logic [ISSUE_NUM-1:0]   validM, regwriteM, memreadM, memwriteM;
    logic [3*ISSUE_NUM-1:0] RW_typeM;
    logic [ISSUE_NUM-1:0]   validW, regwriteW;
    logic [ISSUE_NUM-1:0]   illegalD;
    logic [CNT_W-1:0]       inflight_cnt;

    modport master (
        output validD, opcodeD, func3D, stallE, flushE, redirect_vE, redirect_laneE,
        input  validE, regwriteE, memreadE, memwriteE, jalE, jalrE, branchE, func3E,
               validM, regwriteM, memreadM, memwriteM, RW_typeM,
               validW, regwriteW, illegalD, inflight_cnt
    );
    modport slave (
        input  validD, opcodeD, func3D, stallE, flushE, redirect_vE, redirect_laneE,
        output validE, regwriteE, memreadE, memwriteE, jalE, jalrE, branchE, func3E,
               validM, regwriteM, memreadM, memwriteM, RW_typeM,
               validW, regwriteW, illegalD, inflight_cnt
    );
endinterface

// File: rtl/ctrl_pipe_nway.sv
// ctrl_pipe_nway: N-lane decode in D and control-bundle pipeline through E/M/W; ports: clk, rst_n (async low), bus (slave)
module ctrl_pipe_nway #(
    parameter int ISSUE_NUM = 4,
    parameter int CNT_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ctrl_pipe_nway_if.slave       bus
);
    localparam int N = ISSUE_NUM;

    typedef struct packed {
        logic [N-1:0]   v, rw, mr, mw, jal, jalr, br;
        logic [3*N-1:0] f3;
    } e_t;

    typedef struct packed {
        logic [N-1:0]   v, rw, mr, mw;
        logic [3*N-1:0] rwt;
    } m_t;

    typedef struct packed {
        logic [N-1:0] v, rw;
    } w_t;

    // {known, regwrite, memread, memwrite, branch, jal, jalr}
    function automatic logic [6:0] ctl(input logic [6:0] op);
        logic rw;
        rw = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111, 7'b1100111,
                        7'b0110111, 7'b0010111, 7'b0111011, 7'b0011011};
        return {rw || op == 7'b0100011 || op == 7'b1100011, rw,
                op == 7'b0000011, op == 7'b0100011, op == 7'b1100011,
                op == 7'b1101111, op == 7'b1100111};
    endfunction

    e_t             dec, e_d, e_q;
    m_t             m_d, m_q;
    w_t             w_d, w_q;
    logic [N-1:0]   known, keep;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        dec   = '0;
        known = '0;
        for (int i = 0; i < N; i++) begin
            {known[i], dec.rw[i], dec.mr[i], dec.mw[i], dec.br[i], dec.jal[i], dec.jalr[i]} =
                ctl(bus.opcodeD[7*i +: 7]);
            dec.f3[3*i +: 3] = bus.func3D[3*i +: 3];
        end
        dec.v    = bus.validD;
        dec.rw   = dec.rw & bus.validD;
        dec.mr   = dec.mr & bus.validD;
        dec.mw   = dec.mw & bus.validD;
        dec.br   = dec.br & bus.validD;
        dec.jal  = dec.jal & bus.validD;
        dec.jalr = dec.jalr & bus.validD;
        for (int i = 0; i < N; i++) dec.f3[3*i +: 3] = bus.validD[i] ? dec.f3[3*i +: 3] : 3'b000;
    end

    assign e_d = (bus.flushE || bus.redirect_vE) ? '0 : bus.stallE ? e_q : dec;

    // A lane index at or beyond N kills nothing, since every lane index is below it.
    always_comb begin
        keep = '0;
        for (int i = 0; i < N; i++) keep[i] = !bus.stallE && (!bus.redirect_vE || i <= int'(bus.redirect_laneE));
        m_d    = '0;
        m_d.v  = e_q.v & keep;
        m_d.rw = e_q.rw & keep;
        m_d.mr = e_q.mr & keep;
        m_d.mw = e_q.mw & keep;
        for (int i = 0; i < N; i++) m_d.rwt[3*i +: 3] = (m_d.mr[i] || m_d.mw[i]) ? e_q.f3[3*i +: 3] : 3'b000;
        w_d   = '{v: m_q.v, rw: m_q.rw};
        cnt_d = '0;
        for (int i = 0; i < N; i++) cnt_d = cnt_d + CNT_W'(e_d.v[i]) + CNT_W'(m_d.v[i]) + CNT_W'(w_d.v[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.illegalD     = bus.validD & ~known;
    assign bus.validE       = e_q.v;
    assign bus.regwriteE    = e_q.rw;
    assign bus.memreadE     = e_q.mr;
    assign bus.memwriteE    = e_q.mw;
    assign bus.jalE         = e_q.jal;
    assign bus.jalrE        = e_q.jalr;
    assign bus.branchE      = e_q.br;
    assign bus.func3E       = e_q.f3;
    assign bus.validM       = m_q.v;
    assign bus.regwriteM    = m_q.rw;
    assign bus.memreadM     = m_q.mr;
    assign bus.memwriteM    = m_q.mw;
    assign bus.RW_typeM     = m_q.rwt;
    assign bus.validW       = w_q.v;
    assign bus.regwriteW    = w_q.rw;
    assign bus.inflight_cnt = cnt_q;
endmodule

// File: tb/tb_ctrl_pipe_nway.sv
// tb_ctrl_pipe_nway: directed-vector self-checking bench for ctrl_pipe_nway
module tb_ctrl_pipe_nway;
    localparam logic [6:0] ADDI = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011,
                           BEQ = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, BAD = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    ctrl_pipe_nway_if #(.ISSUE_NUM(4), .CNT_W(5)) bus ();
    ctrl_pipe_nway #(.ISSUE_NUM(4), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [6:0] o3, o2, o1, o0, input logic [11:0] f3);
        bus.validD  = v;
        bus.opcodeD = {o3, o2, o1, o0};
        bus.func3D  = f3;
    endtask

    task automatic chk_v(input string tag, input logic [3:0] e, m, w, input logic [4:0] c);
        chk({tag, ".validE"}, 32'(bus.validE), 32'(e));
        chk({tag, ".validM"}, 32'(bus.validM), 32'(m));
        chk({tag, ".validW"}, 32'(bus.validW), 32'(w));
        chk({tag, ".cnt"}, 32'(bus.inflight_cnt), 32'(c));
    endtask

    initial begin
        drive(4'b0000, ADDI, ADDI, ADDI, ADDI, 12'h000);
        bus.stallE = 1'b0;
        bus.flushE = 1'b0;
        bus.redirect_vE = 1'b0;
        bus.redirect_laneE = 3'd0;
        #2;
        chk_v("reset", 4'b0000, 4'b0000, 4'b0000, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // straight flow: lanes {jal, beq, store, load}, continuous input
        drive(4'b1111, JAL, BEQ, ST, LD, {3'b000, 3'b000, 3'b010, 3'b011});
        step();
        chk("flow.memreadE", 32'(bus.memreadE), 'b0001);
        chk("flow.memwriteE", 32'(bus.memwriteE), 'b0010);
        chk("flow.branchE", 32'(bus.branchE), 'b0100);
        chk("flow.jalE", 32'(bus.jalE), 'b1000);
        chk("flow.regwriteE", 32'(bus.regwriteE), 'b1001);
        chk("flow.func3E", 32'(bus.func3E), 'b000_000_010_011);
        chk_v("flow1", 4'b1111, 4'b0000, 4'b0000, 5'd4);
        step();
        chk("flow.memreadM", 32'(bus.memreadM), 'b0001);
        chk("flow.memwriteM", 32'(bus.memwriteM), 'b0010);
        chk("flow.RW_typeM", 32'(bus.RW_typeM), 'b000_000_010_011);
        chk_v("flow2", 4'b1111, 4'b1111, 4'b0000, 5'd8);
        step();
        chk("flow.regwriteW", 32'(bus.regwriteW), 'b1001);
        chk_v("flow3", 4'b1111, 4'b1111, 4'b1111, 5'd12);

        // stall: B (all addi) in E, then hold two cycles while D offers C
        drive(4'b1111, ADDI, ADDI, ADDI, ADDI, 12'h000);
        step();
        chk("stall.regwriteE0", 32'(bus.regwriteE), 'b1111);
        drive(4'b0101, ADDI, ADDI, ADDI, ADDI, 12'h000);
        bus.stallE = 1'b1;
        step();
        chk_v("stall1", 4'b1111, 4'b0000, 4'b1111, 5'd8);
        chk("stall1.regwriteE", 32'(bus.regwriteE), 'b1111);
        step();
        chk_v("stall2", 4'b1111, 4'b0000, 4'b0000, 5'd4);
        bus.stallE = 1'b0;
        step();
        chk_v("resume", 4'b0101, 4'b1111, 4'b0000, 5'd6);
        chk("resume.regwriteM", 32'(bus.regwriteM), 'b1111);

        // redirect kill of lanes younger than lane 1
        drive(4'b1111, ADDI, ADDI, ADDI, ADDI, 12'h000);
        step();
        chk_v("pre_redir", 4'b1111, 4'b0101, 4'b1111, 5'd10);
        bus.redirect_vE = 1'b1;
        bus.redirect_laneE = 3'd1;
        step();
        chk_v("redir", 4'b0000, 4'b0011, 4'b0101, 5'd4);
        chk("redir.regwriteM", 32'(bus.regwriteM), 'b0011);
        bus.redirect_vE = 1'b0;
        step();
        chk_v("refill", 4'b1111, 4'b0000, 4'b0011, 5'd6);

        // out-of-range redirect lane kills nothing in E->M
        bus.redirect_vE = 1'b1;
        bus.redirect_laneE = 3'd5;
        step();
        chk_v("redir_oob", 4'b0000, 4'b1111, 4'b0000, 5'd4);
        bus.redirect_vE = 1'b0;
        step();
        chk_v("refill2", 4'b1111, 4'b0000, 4'b1111, 5'd8);

        // stall and redirect together: E cleared, M bubble
        bus.stallE = 1'b1;
        bus.redirect_vE = 1'b1;
        bus.redirect_laneE = 3'd3;
        step();
        chk_v("stall_redir", 4'b0000, 4'b0000, 4'b0000, 5'd0);
        bus.stallE = 1'b0;
        bus.redirect_vE = 1'b0;
        step();
        chk_v("fill3", 4'b1111, 4'b0000, 4'b0000, 5'd4);

        // flush: current E contents still move to M
        bus.flushE = 1'b1;
        step();
        chk_v("flush", 4'b0000, 4'b1111, 4'b0000, 5'd4);
        chk("flush.regwriteM", 32'(bus.regwriteM), 'b1111);
        bus.flushE = 1'b0;

        // illegal lane 2, invalid load on lane 3, jalr on lane 1
        drive(4'b0111, LD, BAD, JALR, ADDI, 12'h000);
        #1;
        chk("illegalD", 32'(bus.illegalD), 'b0100);
        step();
        chk("ill.validE", 32'(bus.validE), 'b0111);
        chk("ill.regwriteE", 32'(bus.regwriteE), 'b0011);
        chk("ill.jalrE", 32'(bus.jalrE), 'b0010);
        chk("ill.memreadE", 32'(bus.memreadE), 'b0000);
        chk("ill.other", 32'({bus.memwriteE, bus.branchE, bus.jalE}), 'h000);
        drive(4'b0000, LD, BAD, JALR, ADDI, 12'h000);
        #1;
        chk("illegalD_inv", 32'(bus.illegalD), 'b0000);

        // asynchronous reset mid-flight
        drive(4'b1111, ADDI, ADDI, ADDI, ADDI, 12'h000);
        step();
        step();
        step();
        chk_v("full", 4'b1111, 4'b1111, 4'b1111, 5'd12);
        #2;
        rst_n = 1'b0;
        #1;
        chk_v("async_rst", 4'b0000, 4'b0000, 4'b0000, 5'd0);
        chk("async_rst.rw", 32'({bus.regwriteE, bus.regwriteM, bus.regwriteW}), 'h000);
        rst_n = 1'b1;
        step();
        chk_v("post_rst", 4'b1111, 4'b0000, 4'b0000, 5'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
